// File: rtl/bram_1r1w_cfg.sv
// Simple-dual-port block RAM with one write port and one read port on a single clock.
// It provides per-byte write enables, a read-valid flag, an optional output register
// and a selectable read-during-write policy.
// A clear sequencer zeroes the array after reset before user traffic is accepted.
module bram_1r1w_cfg #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             ready
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam state_t                INIT_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    clr_we;
    logic [DATA_WIDTH-1:0]   rd_word;

    // User traffic is only accepted once the registered ready flag is up.
    assign wr_acc = ready_q & wr_en;
    assign rd_acc = ready_q & rd_en;
    assign clr_we = (state == CLEAR) & ~reset;
    assign ready  = ready_q;

    // State register, clear counter and registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT_STATE;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == RUN);
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Next-state logic: leave CLEAR on the cycle that zeroes the last address.
    always_comb begin
        state_next = state;
        if ((state == CLEAR) && (clr_cnt == LAST_ADDR)) begin
            state_next = RUN;
        end
    end

    // Array write port: the clear sequencer owns the port in CLEAR, the user in RUN.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word with optional same-address bypass of the enabled write lanes.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((RDW_MODE != 0) && wr_acc && (wr_addr == rd_addr)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s1_data;
            logic                  s1_valid;

            // Two-stage read pipeline; rd_data only moves when a result arrives.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_valid <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    s1_valid <= rd_acc;
                    if (rd_acc) begin
                        s1_data <= rd_word;
                    end
                    rd_valid <= s1_valid;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            // Single-stage read; rd_data only moves when a result arrives.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bram_1r1w_cfg.sv
// Scoreboard bench for bram_1r1w_cfg.
// Instances 0-2 share one stimulus stream: defaults, RDW_MODE=1 and OUT_REG=1.
// Instance 3 (CLEAR_ON_RESET=0) has its own stimulus stream.
module tb_bram_1r1w_cfg;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic        reset3 = 1'b1;
    logic        wr_en3 = 1'b0;
    logic [3:0]  wr_addr3 = '0;
    logic [31:0] wr_data3 = '0;
    logic [3:0]  wr_be3 = '0;
    logic        rd_en3 = 1'b0;
    logic [3:0]  rd_addr3 = '0;

    logic [31:0] rd_data [4];
    logic [3:0]  rd_valid;
    logic [3:0]  ready;

    exp_t        sb [4][$];
    int          lat [4] = '{1, 1, 2, 1};
    logic [31:0] last [4];
    logic [3:0]  rst_q = '1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= {reset3, reset, reset, reset};
    end

    bram_1r1w_cfg u_base (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .ready(ready[0])
    );

    bram_1r1w_cfg #(.RDW_MODE(1)) u_rdw1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .ready(ready[1])
    );

    bram_1r1w_cfg #(.OUT_REG(1)) u_oreg (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[2]),
        .rd_valid(rd_valid[2]), .ready(ready[2])
    );

    bram_1r1w_cfg #(.CLEAR_ON_RESET(0)) u_noclr (
        .clk(clk), .reset(reset3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .wr_be(wr_be3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data[3]),
        .rd_valid(rd_valid[3]), .ready(ready[3])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [31:0] data);
        exp_t e;
        e.data = data;
        e.due  = cyc + lat[k];
        sb[k].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        wr_be  = '0;
        wr_en3 = 1'b0;
        rd_en3 = 1'b0;
        wr_be3 = '0;
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    // e_old goes to the RDW_MODE=0 instances, e_new to the RDW_MODE=1 instance.
    task automatic do_rd(input logic [3:0] a, input logic [31:0] e_old, input logic [31:0] e_new);
        rd_en   = 1'b1;
        rd_addr = a;
        push(0, e_old);
        push(1, e_new);
        push(2, e_old);
    endtask

    // Called right after reset is released; expects 16 not-ready cycles, optionally poking the ports.
    task automatic wait_clear(input bit poke);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) check("ready_in_clear", {31'd0, ready[k]}, 32'd0);
            if (poke && i >= 8) begin
                do_wr(4'd1, 32'hBAD0BAD0, 4'hF);
                rd_en   = 1'b1;
                rd_addr = 4'd1;
            end
            tick();
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("ready_after_clear", {31'd0, ready[k]}, 32'd1);
    endtask

    // Monitor: compares every cycle's rd_valid with the scoreboard and checks data or hold.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_q[k]) begin
                check("reset_rd_valid", {31'd0, rd_valid[k]}, 32'd0);
                check("reset_rd_data", rd_data[k], 32'd0);
                last[k] = '0;
            end else begin
                logic exp_v;
                exp_t e;
                exp_v = (sb[k].size() != 0) && (sb[k][0].due == cyc);
                check($sformatf("rd_valid[%0d]", k), {31'd0, rd_valid[k]}, {31'd0, exp_v});
                if (exp_v) begin
                    e = sb[k].pop_front();
                    if (rd_valid[k]) check($sformatf("rd_data[%0d]", k), rd_data[k], e.data);
                end
                if (rd_valid[k]) last[k] = rd_data[k];
                else check($sformatf("rd_hold[%0d]", k), rd_data[k], last[k]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, clear sequence, then all 16 addresses read back-to-back as zero.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear(1'b0);
        for (int a = 0; a < 16; a++) begin
            do_rd(4'(a), 32'h0, 32'h0);
            tick();
        end
        repeat (3) tick();

        // Byte-lane writes and an empty-mask write.
        do_wr(4'd3, 32'hDEADBEEF, 4'hF);        tick();
        do_wr(4'd3, 32'h11223344, 4'b0101);     tick();
        do_wr(4'd3, 32'hFFFFFFFF, 4'b0000);     tick();
        do_rd(4'd3, 32'hDE22BE44, 32'hDE22BE44); tick();

        // Read-during-write on the same and on different addresses.
        do_wr(4'd5, 32'h12345678, 4'hF);        tick();
        do_wr(4'd5, 32'hAAAAAAAA, 4'hF);
        do_rd(4'd5, 32'h12345678, 32'hAAAAAAAA); tick();
        do_rd(4'd5, 32'hAAAAAAAA, 32'hAAAAAAAA); tick();
        do_wr(4'd5, 32'h55555555, 4'b0011);
        do_rd(4'd5, 32'hAAAAAAAA, 32'hAAAA5555); tick();
        do_rd(4'd5, 32'hAAAA5555, 32'hAAAA5555); tick();
        do_wr(4'd6, 32'h66666666, 4'hF);
        do_rd(4'd5, 32'hAAAA5555, 32'hAAAA5555); tick();
        do_rd(4'd6, 32'h66666666, 32'h66666666); tick();
        repeat (3) tick();

        // Pipelined burst of four reads, then idle cycles where rd_data must hold 0x13.
        for (int i = 0; i < 4; i++) begin
            do_wr(4'(i), 32'h10 + 32'(i), 4'hF);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            do_rd(4'(i), 32'h10 + 32'(i), 32'h10 + 32'(i));
            tick();
        end
        repeat (5) tick();

        // Reset during CLEAR restarts the sequence; port activity in CLEAR is ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear(1'b1);
        do_rd(4'd1, 32'h0, 32'h0); tick();
        do_rd(4'd3, 32'h0, 32'h0); tick();
        do_rd(4'd5, 32'h0, 32'h0); tick();
        do_rd(4'd6, 32'h0, 32'h0); tick();
        repeat (3) tick();

        // Instance without clear-on-reset keeps its contents across reset.
        reset3 = 1'b0;
        @(negedge clk);
        check("noclr_ready_reset", {31'd0, ready[3]}, 32'd0);
        tick();
        @(negedge clk);
        check("noclr_ready_first", {31'd0, ready[3]}, 32'd1);
        wr_en3   = 1'b1;
        wr_addr3 = 4'd9;
        wr_data3 = 32'hCAFEF00D;
        wr_be3   = 4'hF;
        tick();
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        @(negedge clk);
        check("noclr_ready_pulse", {31'd0, ready[3]}, 32'd0);
        tick();
        @(negedge clk);
        check("noclr_ready_after", {31'd0, ready[3]}, 32'd1);
        rd_en3   = 1'b1;
        rd_addr3 = 4'd9;
        push(3, 32'hCAFEF00D);
        tick();
        repeat (4) tick();

        for (int k = 0; k < 4; k++) check($sformatf("drain[%0d]", k), 32'(sb[k].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
